cpu_fetch_single: RTL and testbench

- Instruction fetch and next-PC stage that sits directly upstream of the single-cycle control/datapath.
- Owns the PC. Fetches one instruction at a time from a handshaked instruction memory and holds it stable in an instruction register until the core retires it.
- On retire, computes the next PC from the control unit's 2-bit pcsource select: sequential, branch, register jump (jr) or absolute jump (j/jal).
- Flags misaligned targets and halts fetching when one occurs.

---
 rtl/cpu_fetch_single_if.sv | 22 ++
 rtl/cpu_fetch_single.sv | 96 +++++++++
 tb/tb_cpu_fetch_single.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_single_if.sv
// Instruction memory request/response bundle for the fetch stage.
// The fetch stage is the master; the memory is the slave.
interface cpu_fetch_single_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/cpu_fetch_single.sv
// Instruction fetch and next-PC stage: owns the PC, fetches one word at a
// time, holds it until retire, then selects seq/branch/jr/jump target.
module cpu_fetch_single #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    cpu_fetch_single_if.master        imem,
    output logic [31:0]               inst,
    output logic                      inst_valid,
    output logic [31:0]               pc,
    output logic [31:0]               pc4,
    input  logic                      retire,
    input  logic [1:0]                pcsource,
    input  logic [31:0]               rs_data,
    output logic                      addr_err,
    output logic [31:0]               instret
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic        take;
    logic        misaligned;
    logic        got;

    assign pc4            = pc + 32'd4;
    assign imem.imem_addr = pc;
    assign br_off         = {{14{inst[15]}}, inst[15:0], 2'b00};
    assign take           = (state == EXEC) && retire;
    assign got            = (state == FETCH) && imem.imem_ack;
    assign misaligned     = next_pc[1:0] != 2'b00;

    always_comb begin
        next_pc = pc4;
        unique case (pcsource)
            2'b00: next_pc = pc4;
            2'b01: next_pc = pc4 + br_off;
            2'b10: next_pc = rs_data;
            2'b11: next_pc = {pc4[31:28], inst[25:0], 2'b00};
            default: next_pc = pc4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: if (imem.imem_ack) state_nxt = EXEC;
            EXEC:  if (retire) state_nxt = misaligned ? ERR : FETCH;
            ERR:   state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req = 1'b0;
        inst_valid    = 1'b0;
        unique case (state)
            FETCH: imem.imem_req = 1'b1;
            EXEC:  inst_valid    = 1'b1;
            default: ;
        endcase
    end

    // pc keeps the offending target after a misaligned jr for debug
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            inst     <= 32'h0;
            addr_err <= 1'b0;
            instret  <= 32'h0;
        end else begin
            if (got) inst <= imem.imem_rdata;
            if (take) begin
                pc      <= next_pc;
                instret <= instret + 32'd1;
                if (misaligned) addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_fetch_single.sv
// Directed bench for cpu_fetch_single: vector table of fetch/retire steps
// plus hand-written error, wait-state and reset-during-fetch sequences.
module tb_cpu_fetch_single;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        retire = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] inst, pc, pc4, instret;
    logic        inst_valid, addr_err;

    logic [31:0] b_inst, b_pc, b_pc4, b_instret;
    logic        b_inst_valid, b_addr_err;

    int n_vec  = 0;
    int n_fail = 0;

    cpu_fetch_single_if bus ();
    cpu_fetch_single_if b_bus ();

    always #5 clk = ~clk;

    cpu_fetch_single dut (
        .clk(clk), .rst(rst), .imem(bus.master),
        .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc4(pc4),
        .retire(retire), .pcsource(pcsource), .rs_data(rs_data),
        .addr_err(addr_err), .instret(instret)
    );

    cpu_fetch_single #(.RESET_PC(32'hBFC0_0000)) dut_b (
        .clk(clk), .rst(rst), .imem(b_bus.master),
        .inst(b_inst), .inst_valid(b_inst_valid), .pc(b_pc), .pc4(b_pc4),
        .retire(1'b0), .pcsource(2'b00), .rs_data(32'h0),
        .addr_err(b_addr_err), .instret(b_instret)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [1:0]  ps;
        logic [31:0] rs;
        logic [31:0] next;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] w,
                         input int dly, input logic r_wait);
        int k;
        k = 0;
        while (!bus.imem_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("fetch_req", {31'h0, bus.imem_req}, 32'h1);
        chk("fetch_addr", bus.imem_addr, a);
        for (int i = 0; i < dly; i++) begin
            retire = r_wait;
            @(negedge clk);
            chk("wait_req", {31'h0, bus.imem_req}, 32'h1);
            chk("wait_addr", bus.imem_addr, a);
            chk("wait_valid", {31'h0, inst_valid}, 32'h0);
        end
        retire = 1'b0;
        chk("ack_cycle_valid", {31'h0, inst_valid}, 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        chk("inst_valid", {31'h0, inst_valid}, 32'h1);
        chk("inst", inst, w);
        chk("req_drop", {31'h0, bus.imem_req}, 32'h0);
    endtask

    task automatic do_retire(input logic [1:0] ps, input logic [31:0] rs);
        retire   = 1'b1;
        pcsource = ps;
        rs_data  = rs;
        @(negedge clk);
        retire   = 1'b0;
        pcsource = 2'b00;
        rs_data  = 32'h0;
    endtask

    initial begin
        logic [31:0] cnt;
        logic        bad;

        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = 32'h0;
        b_bus.imem_ack   = 1'b0;
        b_bus.imem_rdata = 32'h0;

        vecs[0]  = '{32'h0000_0000, 32'h1111_0000, 2'b00, 32'h0, 32'h0000_0004};
        vecs[1]  = '{32'h0000_0004, 32'h2222_0000, 2'b00, 32'h0, 32'h0000_0008};
        vecs[2]  = '{32'h0000_0008, 32'h3333_0000, 2'b00, 32'h0, 32'h0000_000C};
        vecs[3]  = '{32'h0000_000C, 32'h0000_0000, 2'b10, 32'h40, 32'h0000_0040};
        vecs[4]  = '{32'h0000_0040, 32'h1000_FFFF, 2'b01, 32'h0, 32'h0000_0040};
        vecs[5]  = '{32'h0000_0040, 32'h1000_0003, 2'b01, 32'h0, 32'h0000_0050};
        vecs[6]  = '{32'h0000_0050, 32'h0000_0000, 2'b10, 32'h1000_0010, 32'h1000_0010};
        vecs[7]  = '{32'h1000_0010, 32'h0800_0100, 2'b11, 32'h0, 32'h1000_0400};
        vecs[8]  = '{32'h1000_0400, 32'h0000_0000, 2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[9]  = '{32'hFFFF_FFFC, 32'h0000_0000, 2'b00, 32'h0, 32'h0000_0000};
        vecs[10] = '{32'h0000_0000, 32'h0BFF_FFFF, 2'b11, 32'h0, 32'h0FFF_FFFC};
        vecs[11] = '{32'h0FFF_FFFC, 32'h0000_7FFF, 2'b01, 32'h0, 32'h1001_FFFC};

        do_reset();
        chk("idle_req", {31'h0, bus.imem_req}, 32'h0);
        chk("idle_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_err", {31'h0, addr_err}, 32'h0);
        chk("b_idle_req", {31'h0, b_bus.imem_req}, 32'h0);
        @(negedge clk);
        chk("b_first_req", {31'h0, b_bus.imem_req}, 32'h1);
        chk("b_first_addr", b_bus.imem_addr, 32'hBFC0_0000);

        cnt = 32'h0;
        for (int v = 0; v < 12; v++) begin
            fetch(vecs[v].addr, vecs[v].word, 0, 1'b0);
            chk("pc", pc, vecs[v].addr);
            chk("pc4", pc4, vecs[v].addr + 32'd4);
            do_retire(vecs[v].ps, vecs[v].rs);
            cnt = cnt + 32'd1;
            chk("next_addr", bus.imem_addr, vecs[v].next);
            chk("instret", instret, cnt);
            chk("no_err", {31'h0, addr_err}, 32'h0);
        end

        // misaligned jr: sticky error, fetch halted, retire ignored
        fetch(32'h1001_FFFC, 32'h0, 0, 1'b0);
        do_retire(2'b10, 32'h0000_2002);
        cnt = cnt + 32'd1;
        chk("err_flag", {31'h0, addr_err}, 32'h1);
        chk("err_pc", pc, 32'h0000_2002);
        chk("err_valid", {31'h0, inst_valid}, 32'h0);
        chk("err_instret", instret, cnt);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            retire = i[0];
            @(negedge clk);
            if (bus.imem_req !== 1'b0 || inst_valid !== 1'b0) bad = 1'b1;
        end
        retire = 1'b0;
        chk("err_quiet", {31'h0, bad}, 32'h0);
        chk("err_instret_hold", instret, cnt);
        chk("err_pc_hold", pc, 32'h0000_2002);
        chk("err_sticky", {31'h0, addr_err}, 32'h1);

        do_reset();
        chk("rec_pc", pc, 32'h0);
        chk("rec_err", {31'h0, addr_err}, 32'h0);
        chk("rec_instret", instret, 32'h0);
        chk("rec_inst", inst, 32'h0);

        // three wait states with retire held during the wait
        fetch(32'h0, 32'hCAFE_0001, 3, 1'b1);
        chk("wait_instret", instret, 32'h0);
        chk("wait_pc", pc, 32'h0);
        do_retire(2'b00, 32'h0);
        chk("wait_next", bus.imem_addr, 32'h4);
        chk("wait_instret1", instret, 32'h1);

        // reset in the second wait cycle with a stale ack through IDLE
        @(negedge clk);
        chk("w2_req", {31'h0, bus.imem_req}, 32'h1);
        rst            = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rstw_inst", inst, 32'h0);
        chk("rstw_valid", {31'h0, inst_valid}, 32'h0);
        chk("rstw_req", {31'h0, bus.imem_req}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        chk("stale_inst", inst, 32'h0);
        chk("stale_valid", {31'h0, inst_valid}, 32'h0);
        chk("restart_addr", bus.imem_addr, 32'h0);
        chk("restart_instret", instret, 32'h0);
        fetch(32'h0, 32'h1234_5678, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
